// File: rtl/cva5_types.sv
// ============================================================================
// Package : cva5_types
// Shared types for the data-cache Wishbone bridge: posted-write entry, FSM state.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cva5_types;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_wbuf_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } bridge_state_t;

endpackage

`default_nettype wire

// File: rtl/cva5_fifo.sv
// ============================================================================
// Module : cva5_fifo
// Synchronous FIFO with registered full/empty flags and an occupancy count.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cva5_fifo #(
    parameter type DATA_TYPE  = logic,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  DATA_TYPE                      i_data,
    output DATA_TYPE                      o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);
    localparam int c_AW = $clog2(FIFO_DEPTH);

    DATA_TYPE          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;
    logic [c_AW:0]     w_count_next;
    logic              r_full;
    logic              r_empty;

    assign w_count_next = r_count + (c_AW+1)'(i_push) - (c_AW+1)'(i_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == (c_AW+1)'(FIFO_DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/dcache_wb_bridge.sv
// ============================================================================
// Module : dcache_wb_bridge
// L1 data-cache memory port to Wishbone classic master with posted writes.
// Optional bus watchdog: define DCACHE_WB_BRIDGE_TIMEOUT_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dcache_wb_bridge
    import cva5_types::*;
#(
    parameter int WBUF_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    output logic        ack,
    input  logic [29:0] addr,
    input  logic        rnw,
    input  logic [4:0]  rlen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        write_outstanding,
    output logic        bus_error,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);
    localparam int c_CW = $clog2(WBUF_DEPTH) + 1;

    bridge_state_t   r_state, w_state_next;
    logic [29:0]     r_base;
    logic [4:0]      r_rlen, r_beat;
    logic            r_rvalid, r_bus_error;
    logic [31:0]     r_rdata;
    wb_wbuf_entry_t  w_push_entry, w_head;
    logic            w_full, w_empty;
    logic [c_CW-1:0] w_count;
    logic            w_wr_ready, w_rd_ready, w_accept_wr, w_accept_rd;
    logic            w_cyc, w_term, w_timeout, w_forced, w_pop, w_more;

    assign w_wr_ready  = ~w_full & (r_state != READ);
    assign w_rd_ready  = w_empty & (r_state == IDLE);
    assign ack         = request & (rnw ? w_rd_ready : w_wr_ready);
    assign w_accept_wr = request & ~rnw & w_wr_ready;
    assign w_accept_rd = request &  rnw & w_rd_ready;

    assign w_cyc    = (r_state != IDLE);
    assign w_term   = w_cyc & (wb_ack_i | wb_err_i | w_timeout);
    assign w_forced = w_timeout & ~wb_ack_i & ~wb_err_i;
    assign w_pop    = (r_state == WRITE) & w_term;
    // Stay on the bus if the popped entry was not the last, including a same-cycle push.
    assign w_more   = (w_count > c_CW'(1)) | w_accept_wr;

    assign w_push_entry = '{addr: addr, data: wdata, be: wbe};

    cva5_fifo #(
        .DATA_TYPE  (wb_wbuf_entry_t),
        .FIFO_DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept_wr),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef DCACHE_WB_BRIDGE_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [c_TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || !w_cyc || w_term) r_tmo_cnt <= '0;
        else                         r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_timeout = w_cyc & (r_tmo_cnt == c_TW'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog in this build: a non-negative limit never fires.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_next = r_state;
        wb_cyc_o     = 1'b0;
        wb_stb_o     = 1'b0;
        wb_we_o      = 1'b0;
        wb_adr_o     = '0;
        wb_dat_o     = '0;
        wb_sel_o     = '0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty)         w_state_next = WRITE;
                else if (w_accept_rd) w_state_next = READ;
            end
            WRITE: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = w_head.addr;
                wb_dat_o = w_head.data;
                wb_sel_o = w_head.be;
                if (w_term && !w_more) w_state_next = IDLE;
            end
            READ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_sel_o = 4'hF;
                wb_adr_o = r_base + {25'b0, r_beat};
                if (w_term && (r_beat == r_rlen)) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_rlen      <= '0;
            r_beat      <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= 1'b0;
            if (w_accept_rd) begin
                r_base <= addr;
                r_rlen <= rlen;
                r_beat <= '0;
            end
            if ((r_state == READ) && w_term) begin
                r_beat   <= r_beat + 1'b1;
                r_rvalid <= 1'b1;
                r_rdata  <= w_forced ? 32'hDEADBEEF : wb_dat_i;
            end
            if (w_term && (wb_err_i || w_forced)) r_bus_error <= 1'b1;
        end
    end

    assign rvalid            = r_rvalid;
    assign rdata             = r_rdata;
    assign bus_error         = r_bus_error;
    assign write_outstanding = ~w_empty | (r_state == WRITE);

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb_bridge.sv
// ============================================================================
// Module : tb_dcache_wb_bridge
// Directed self-checking bench for dcache_wb_bridge.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dcache_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic        ack;
    logic [29:0] addr;
    logic        rnw;
    logic [4:0]  rlen;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        rvalid;
    logic [31:0] rdata;
    logic        write_outstanding;
    logic        bus_error;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;
    logic [31:0] wb_dat_i;

    int n_checks = 0;
    int n_errors = 0;
    int rv_count;
    int cyc_cnt;
    int guard;

    logic [29:0] fill_adr [8];

    always #5 clk = ~clk;

    dcache_wb_bridge #(
        .WBUF_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .request           (request),
        .ack               (ack),
        .addr              (addr),
        .rnw               (rnw),
        .rlen              (rlen),
        .wdata             (wdata),
        .wbe               (wbe),
        .rvalid            (rvalid),
        .rdata             (rdata),
        .write_outstanding (write_outstanding),
        .bus_error         (bus_error),
        .wb_cyc_o          (wb_cyc_o),
        .wb_stb_o          (wb_stb_o),
        .wb_we_o           (wb_we_o),
        .wb_adr_o          (wb_adr_o),
        .wb_dat_o          (wb_dat_o),
        .wb_sel_o          (wb_sel_o),
        .wb_ack_i          (wb_ack_i),
        .wb_err_i          (wb_err_i),
        .wb_dat_i          (wb_dat_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fill_adr = '{30'h3FFFFFFE, 30'h3FFFFFFF, 30'h0, 30'h1, 30'h2, 30'h3, 30'h4, 30'h5};
        rst = 1'b1; request = 1'b0; addr = '0; rnw = 1'b0; rlen = '0;
        wdata = '0; wbe = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_wo", write_outstanding, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_berr", bus_error, 0);
        rst = 1'b0;
        tick();

        // Single posted write
        request = 1'b1; rnw = 1'b0; addr = 30'h100; wdata = 32'hA5A5A5A5; wbe = 4'b0011;
        #1 chk("wr_ack", ack, 1);
        tick();
        request = 1'b0;
        #1 chk("wr_wo_buffered", write_outstanding, 1);
        chk("wr_cyc_idle", wb_cyc_o, 0);
        tick();
        #1 chk("wr_cyc", wb_cyc_o, 1);
        chk("wr_we", wb_we_o, 1);
        chk("wr_adr", wb_adr_o, 32'h100);
        chk("wr_sel", wb_sel_o, 4'b0011);
        chk("wr_dat", wb_dat_o, 32'hA5A5A5A5);
        tick();
        wb_ack_i = 1'b1;
        #1 chk("wr_wo_at_ack", write_outstanding, 1);
        tick();
        wb_ack_i = 1'b0;
        #1 chk("wr_cyc_done", wb_cyc_o, 0);
        chk("wr_wo_done", write_outstanding, 0);
        tick();

        // 8-beat line fill wrapping the address space
        request = 1'b1; rnw = 1'b1; addr = 30'h3FFFFFFE; rlen = 5'd7;
        #1 chk("fill_ack", ack, 1);
        tick();
        request = 1'b0; rv_count = 0;
        for (int i = 0; i < 8; i++) begin
            wb_ack_i = 1'b1; wb_dat_i = 32'h1000_0000 + i;
            #1 chk("fill_adr", wb_adr_o, fill_adr[i]);
            chk("fill_cyc", wb_cyc_o, 1);
            chk("fill_we", wb_we_o, 0);
            chk("fill_rvalid", rvalid, (i > 0));
            if (i > 0) chk("fill_rdata", rdata, 32'h1000_0000 + i - 1);
            rv_count += rvalid;
            tick();
        end
        wb_ack_i = 1'b0;
        #1 rv_count += rvalid;
        chk("fill_rdata_last", rdata, 32'h1000_0007);
        chk("fill_cyc_done", wb_cyc_o, 0);
        tick();
        #1 chk("fill_rvalid_done", rvalid, 0);
        chk("fill_pulses", rv_count, 8);
        tick();

        // Fill the write buffer with the slave stalled; read must wait
        for (int k = 0; k < 4; k++) begin
            request = 1'b1; rnw = 1'b0; addr = 30'h200 + k; wdata = 32'hB000_0000 + k; wbe = 4'hF;
            #1 chk("wbuf_ack", ack, 1);
            tick();
        end
        addr = 30'h204;
        #1 chk("wbuf_full_ack", ack, 0);
        chk("wbuf_stall_adr", wb_adr_o, 32'h200);
        tick();
        request = 1'b1; rnw = 1'b1; addr = 30'h50; rlen = 5'd0;
        for (int k = 0; k < 4; k++) begin
            wb_ack_i = 1'b1;
            #1 chk("wbuf_drain_adr", wb_adr_o, 32'h200 + k);
            chk("wbuf_drain_dat", wb_dat_o, 32'hB000_0000 + k);
            chk("wbuf_rd_blocked", ack, 0);
            tick();
        end
        wb_ack_i = 1'b0;
        #1 chk("wbuf_rd_ack", ack, 1);
        chk("wbuf_wo_clear", write_outstanding, 0);
        tick();
        request = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE0001;
        #1 chk("rd_adr", wb_adr_o, 32'h50);
        chk("rd_sel", wb_sel_o, 4'hF);
        tick();
        wb_ack_i = 1'b0;
        #1 chk("rd_rvalid", rvalid, 1);
        chk("rd_rdata", rdata, 32'hCAFE0001);
        chk("rd_cyc_done", wb_cyc_o, 0);
        tick();

        // Simultaneous push and pop keeps the bus busy
        request = 1'b1; rnw = 1'b0; addr = 30'h300; wdata = 32'h11111111; wbe = 4'hF;
        #1 chk("pp_ack0", ack, 1);
        tick();
        request = 1'b0;
        tick();
        request = 1'b1; addr = 30'h301; wdata = 32'h22222222; wb_ack_i = 1'b1;
        #1 chk("pp_adr0", wb_adr_o, 32'h300);
        chk("pp_ack1", ack, 1);
        tick();
        request = 1'b0;
        #1 chk("pp_cyc1", wb_cyc_o, 1);
        chk("pp_adr1", wb_adr_o, 32'h301);
        chk("pp_dat1", wb_dat_o, 32'h22222222);
        tick();
        wb_ack_i = 1'b0;
        #1 chk("pp_cyc_done", wb_cyc_o, 0);
        chk("pp_wo_done", write_outstanding, 0);
        tick();

        // Error on beat 2 of a 4-beat read
        request = 1'b1; rnw = 1'b1; addr = 30'h80; rlen = 5'd3;
        #1 chk("err_ack", ack, 1);
        tick();
        request = 1'b0; rv_count = 0;
        for (int i = 0; i < 4; i++) begin
            wb_ack_i = (i != 2); wb_err_i = (i == 2); wb_dat_i = 32'hEEEE0000 + i;
            #1 rv_count += rvalid;
            chk("err_adr", wb_adr_o, 32'h80 + i);
            chk("err_berr", bus_error, (i == 3));
            if (i == 3) chk("err_rdata", rdata, 32'hEEEE0002);
            tick();
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1 rv_count += rvalid;
        chk("err_rdata_last", rdata, 32'hEEEE0003);
        chk("err_cyc_done", wb_cyc_o, 0);
        chk("err_pulses", rv_count, 4);
        repeat (3) tick();
        #1 chk("err_sticky", bus_error, 1);
        tick();

        // Reset in the middle of a burst
        request = 1'b1; rnw = 1'b1; addr = 30'h10; rlen = 5'd7;
        #1 chk("mrst_ack", ack, 1);
        tick();
        request = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h1;
        tick();
        wb_dat_i = 32'h2;
        tick();
        rst = 1'b1; wb_dat_i = 32'h3;
        #1 chk("mrst_cyc_before", wb_cyc_o, 1);
        tick();
        rst = 1'b0; wb_ack_i = 1'b0;
        #1 chk("mrst_cyc", wb_cyc_o, 0);
        chk("mrst_rvalid", rvalid, 0);
        chk("mrst_wo", write_outstanding, 0);
        chk("mrst_berr", bus_error, 0);
        request = 1'b1; rnw = 1'b1; addr = 30'h0; rlen = 5'd0;
        #1 chk("mrst_rd_ready", ack, 1);
        request = 1'b0;
        tick();
        tick();

`ifdef DCACHE_WB_BRIDGE_TIMEOUT_EN
        // Slave never answers: watchdog terminates the read
        request = 1'b1; rnw = 1'b1; addr = 30'h20; rlen = 5'd0;
        #1 chk("tmo_ack", ack, 1);
        tick();
        request = 1'b0; cyc_cnt = 0; guard = 0;
        while (!rvalid && guard < 40) begin
            if (wb_cyc_o) cyc_cnt++;
            guard++;
            tick();
        end
        chk("tmo_rvalid", rvalid, 1);
        chk("tmo_cycles", cyc_cnt, 16);
        chk("tmo_rdata", rdata, 32'hDEADBEEF);
        chk("tmo_berr", bus_error, 1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
